remote_cmd_decoder: RTL

- Receive-side partner of the keyboard-to-UART forwarding path. The local PS2 keystroke bytes go out over the UART link; this block interprets the bytes arriving from the remote board.
- Consumes the byte strobe and data from uart_ctl and produces clean held-button levels for the second player sprite (up/left/right), plus a start pulse.
- Replaces direct last-byte comparison: adds press/release semantics, a hold timeout for link-loss safety, left/right exclusion, link-alive indication and an error counter.

---
 rtl/remote_cmd_pkg.sv | 23 ++
 rtl/remote_cmd_decoder_if.sv | 26 ++
 rtl/key_hold_timer.sv | 57 +++++
 rtl/remote_cmd_decoder.sv | 106 ++++++++++
 4 files changed

// File: rtl/remote_cmd_pkg.sv
// Byte codes, key state encoding and timer sizing
// shared by the remote command decoder files.
package remote_cmd_pkg;

  localparam logic [7:0] CMD_UP_P    = 8'h57;
  localparam logic [7:0] CMD_UP_R    = 8'h77;
  localparam logic [7:0] CMD_LEFT_P  = 8'h41;
  localparam logic [7:0] CMD_LEFT_R  = 8'h61;
  localparam logic [7:0] CMD_RIGHT_P = 8'h44;
  localparam logic [7:0] CMD_RIGHT_R = 8'h64;
  localparam logic [7:0] CMD_START   = 8'h53;

  typedef enum logic {
    KEY_RELEASED = 1'b0,
    KEY_HELD     = 1'b1
  } key_state_e;

  // Counter width able to hold n-1, never zero.
  function automatic int tmr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/remote_cmd_decoder_if.sv
// Rx byte strobe in, remote button levels out.
// master: byte source side; slave: the decoder.
interface remote_cmd_decoder_if #(
  parameter int ERR_W = 8
);
  logic             rx_done;
  logic [7:0]       rx_data;
  logic             btn_up;
  logic             btn_left;
  logic             btn_right;
  logic             start_pulse;
  logic             link_alive;
  logic [ERR_W-1:0] err_count;

  modport master (
    output rx_done, rx_data,
    input  btn_up, btn_left, btn_right,
    input  start_pulse, link_alive, err_count
  );

  modport slave (
    input  rx_done, rx_data,
    output btn_up, btn_left, btn_right,
    output start_pulse, link_alive, err_count
  );
endinterface

// File: rtl/key_hold_timer.sv
// One remote key: press/release FSM with hold timeout.
// Ports: clk, resetn, i_press, i_release, i_force_release, o_held.
module key_hold_timer
  import remote_cmd_pkg::*;
#(
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_press,
  input  logic i_release,
  input  logic i_force_release,
  output logic o_held
);

  localparam int TW = tmr_w(HOLD_CYCLES);
  localparam logic [TW-1:0] RELOAD =
    TW'(HOLD_CYCLES - 1);

  key_state_e      r_state;
  key_state_e      w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= KEY_RELEASED;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Press outranks timeout so a refresh on the
  // expiry cycle keeps the key held.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    if (i_press) begin
      w_state_nxt = KEY_HELD;
      w_timer_nxt = RELOAD;
    end else if (i_release || i_force_release) begin
      w_state_nxt = KEY_RELEASED;
      w_timer_nxt = '0;
    end else if (r_state == KEY_HELD) begin
      if (r_timer == '0) begin
        w_state_nxt = KEY_RELEASED;
      end else begin
        w_timer_nxt = r_timer - 1'b1;
      end
    end
  end

  assign o_held = (r_state == KEY_HELD);

endmodule

// File: rtl/remote_cmd_decoder.sv
// Decodes remote UART bytes into held buttons, start,
// link-alive and error count. Ports: clk, resetn, bus.
module remote_cmd_decoder
  import remote_cmd_pkg::*;
#(
  parameter int HOLD_CYCLES = 25000000,
  parameter int LINK_CYCLES = 100000000,
  parameter int ERR_W       = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  remote_cmd_decoder_if.slave  bus
);

  localparam int LW = tmr_w(LINK_CYCLES);
  localparam logic [LW-1:0] LINK_RELOAD =
    LW'(LINK_CYCLES - 1);

  logic w_up_p, w_up_r;
  logic w_left_p, w_left_r;
  logic w_right_p, w_right_r;
  logic w_start, w_err;

  logic [LW-1:0]    r_link_timer;
  logic             r_link_alive;
  logic             r_start;
  logic [ERR_W-1:0] r_err;

  always_comb begin
    w_up_p    = 1'b0;
    w_up_r    = 1'b0;
    w_left_p  = 1'b0;
    w_left_r  = 1'b0;
    w_right_p = 1'b0;
    w_right_r = 1'b0;
    w_start   = 1'b0;
    w_err     = 1'b0;
    if (bus.rx_done) begin
      unique case (bus.rx_data)
        CMD_UP_P:    w_up_p    = 1'b1;
        CMD_UP_R:    w_up_r    = 1'b1;
        CMD_LEFT_P:  w_left_p  = 1'b1;
        CMD_LEFT_R:  w_left_r  = 1'b1;
        CMD_RIGHT_P: w_right_p = 1'b1;
        CMD_RIGHT_R: w_right_r = 1'b1;
        CMD_START:   w_start   = 1'b1;
        default:     w_err     = 1'b1;
      endcase
    end
  end

  key_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_up (
    .clk             (clk),
    .resetn          (resetn),
    .i_press         (w_up_p),
    .i_release       (w_up_r),
    .i_force_release (1'b0),
    .o_held          (bus.btn_up)
  );

  // Opposite direction press drops the other side.
  key_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_left (
    .clk             (clk),
    .resetn          (resetn),
    .i_press         (w_left_p),
    .i_release       (w_left_r),
    .i_force_release (w_right_p),
    .o_held          (bus.btn_left)
  );

  key_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_right (
    .clk             (clk),
    .resetn          (resetn),
    .i_press         (w_right_p),
    .i_release       (w_right_r),
    .i_force_release (w_left_p),
    .o_held          (bus.btn_right)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_link_timer <= '0;
      r_link_alive <= 1'b0;
      r_start      <= 1'b0;
      r_err        <= '0;
    end else begin
      r_start <= w_start;
      if (bus.rx_done) begin
        r_link_timer <= LINK_RELOAD;
        r_link_alive <= 1'b1;
      end else if (r_link_timer == '0) begin
        r_link_alive <= 1'b0;
      end else begin
        r_link_timer <= r_link_timer - 1'b1;
      end
      if (w_err && (r_err != '1)) begin
        r_err <= r_err + 1'b1;
      end
    end
  end

  assign bus.start_pulse = r_start;
  assign bus.link_alive  = r_link_alive;
  assign bus.err_count   = r_err;

endmodule
